// File: rtl/wb_drp_multi_pkg.sv
// Shared definitions for the Wishbone-to-multi-DRP bridge.
//   state_t          : bridge FSM encoding (IDLE / WAIT / DONE)
//   DEFAULT_TIMEOUT  : default DRP wait-cycle limit
//   min1_clog2()     : ceil(log2(n)) but never below 1, for select/counter widths
package wb_drp_multi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_TIMEOUT = 255;

  function automatic int unsigned min1_clog2(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_drp_multi_if.sv
// Wishbone classic bus bundle between the interconnect and the DRP bridge.
//   wb_adr_i  {port select, DRP address}
//   wb_dat_i  write data          wb_dat_o  read data
//   wb_we_i   write enable        wb_stb_i  strobe     wb_cyc_i  bus cycle
//   wb_ack_o  normal termination  wb_err_o  error termination
// The _i/_o suffixes are relative to the slave (bridge).
interface wb_drp_multi_if #(
  parameter int unsigned ADR_W = 18,
  parameter int unsigned DAT_W = 16
);
  logic [ADR_W-1:0] wb_adr_i;
  logic [DAT_W-1:0] wb_dat_i;
  logic [DAT_W-1:0] wb_dat_o;
  logic             wb_we_i;
  logic             wb_stb_i;
  logic             wb_ack_o;
  logic             wb_err_o;
  logic             wb_cyc_i;

  modport master (
    output wb_adr_i, wb_dat_i, wb_we_i, wb_stb_i, wb_cyc_i,
    input  wb_dat_o, wb_ack_o, wb_err_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_we_i, wb_stb_i, wb_cyc_i,
    output wb_dat_o, wb_ack_o, wb_err_o
  );
endinterface

// File: rtl/wb_drp_multi.sv
// Wishbone classic slave bridging to PORTS independent Xilinx DRP ports.
// Upper address bits select the port, the low ADDR_WIDTH bits are the DRP
// address. A bounded wait (TIMEOUT cycles, 0 = unbounded) ends hung accesses
// with wb_err_o and all-ones read data.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   wb          Wishbone slave bundle (see wb_drp_multi_if)
//   drp_addr    per-port DRP address,    port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
//   drp_do      per-port DRP write data, port p at [p*DATA_WIDTH +: DATA_WIDTH]
//   drp_di      per-port DRP read data
//   drp_en/we   per-port enable / write enable (one-cycle pulse)
//   drp_rdy     per-port ready
module wb_drp_multi
  import wb_drp_multi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned PORTS      = 4,
  parameter int unsigned TIMEOUT    = DEFAULT_TIMEOUT
) (
  input  logic                        clk,
  input  logic                        rst_n,
  wb_drp_multi_if.slave               wb,
  output logic [PORTS*ADDR_WIDTH-1:0] drp_addr,
  output logic [PORTS*DATA_WIDTH-1:0] drp_do,
  input  logic [PORTS*DATA_WIDTH-1:0] drp_di,
  output logic [PORTS-1:0]            drp_en,
  output logic [PORTS-1:0]            drp_we,
  input  logic [PORTS-1:0]            drp_rdy
);

  localparam int unsigned SEL_WIDTH = min1_clog2(PORTS);
  localparam int unsigned CNT_W     = min1_clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

  state_t                 state;
  logic [SEL_WIDTH-1:0]   sel_q;
  logic                   we_q;
  logic [CNT_W-1:0]       cnt;

  logic [SEL_WIDTH-1:0]   sel_in;
  logic [ADDR_WIDTH-1:0]  addr_in;
  logic                   req;
  logic                   sel_ok;
  logic                   start;
  logic                   timeout_hit;
  logic                   rdy_sel;
  logic [DATA_WIDTH-1:0]  di_sel;

  assign sel_in  = wb.wb_adr_i[ADDR_WIDTH +: SEL_WIDTH];
  assign addr_in = wb.wb_adr_i[ADDR_WIDTH-1:0];
  assign req     = (state == ST_IDLE) && wb.wb_cyc_i && wb.wb_stb_i &&
                   !wb.wb_ack_o && !wb.wb_err_o;
  assign sel_ok  = int'(sel_in) < int'(PORTS);
  assign start   = req && sel_ok;
  assign timeout_hit = (TIMEOUT != 0) && (cnt >= CNT_LIMIT);

  // Only the latched port's ready/data are visible; other ports' rdy is ignored.
  always_comb begin
    rdy_sel = 1'b0;
    di_sel  = '0;
    for (int unsigned p = 0; p < PORTS; p++) begin
      if (sel_q == SEL_WIDTH'(p)) begin
        rdy_sel = drp_rdy[p];
        di_sel  = drp_di[p*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  for (genvar p = 0; p < PORTS; p++) begin : g_port
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] do_q;
    logic                  en_q;
    logic                  we_p;
    logic                  hit;

    assign hit = start && (sel_in == SEL_WIDTH'(p));

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        addr_q <= '0;
        do_q   <= '0;
        en_q   <= 1'b0;
        we_p   <= 1'b0;
      end else begin
        en_q <= hit;
        we_p <= hit && wb.wb_we_i;
        if (hit) begin
          addr_q <= addr_in;
          do_q   <= wb.wb_dat_i;
        end
      end
    end

    assign drp_addr[p*ADDR_WIDTH +: ADDR_WIDTH] = addr_q;
    assign drp_do[p*DATA_WIDTH +: DATA_WIDTH]   = do_q;
    assign drp_en[p] = en_q;
    assign drp_we[p] = we_p;
  end

  // ack/err are registered on entry to DONE and gated by cyc at that edge,
  // so an abandoned cycle still drains the DRP access silently.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      sel_q       <= '0;
      we_q        <= 1'b0;
      cnt         <= '0;
      wb.wb_dat_o <= '0;
      wb.wb_ack_o <= 1'b0;
      wb.wb_err_o <= 1'b0;
    end else begin
      wb.wb_ack_o <= 1'b0;
      wb.wb_err_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            sel_q <= sel_in;
            we_q  <= wb.wb_we_i;
            if (sel_ok) begin
              cnt   <= '0;
              state <= ST_WAIT;
            end else begin
              wb.wb_err_o <= 1'b1;
              state       <= ST_DONE;
            end
          end
        end
        ST_WAIT: begin
          if (rdy_sel) begin
            if (!we_q) wb.wb_dat_o <= di_sel;
            wb.wb_ack_o <= wb.wb_cyc_i;
            state       <= ST_DONE;
          end else if (timeout_hit) begin
            wb.wb_dat_o <= '1;
            wb.wb_err_o <= wb.wb_cyc_i;
            state       <= ST_DONE;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_drp_multi.sv
// Bench for wb_drp_multi: DUT A (4 ports, timeout 16) and DUT B (3 ports,
// timeout 16). Stimulus pushes expected Wishbone responses into per-DUT
// queues; negedge monitors pop and compare whenever ack or err is seen.
module tb_wb_drp_multi;
  import wb_drp_multi_pkg::*;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned PA = 4;
  localparam int unsigned PB = 3;
  localparam int unsigned TO = 16;
  localparam int unsigned SW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic          err;
    logic [DW-1:0] dat;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;

  wb_drp_multi_if #(.ADR_W(AW+SW), .DAT_W(DW)) bus_a ();
  wb_drp_multi_if #(.ADR_W(AW+SW), .DAT_W(DW)) bus_b ();

  logic [PA*AW-1:0] a_addr;
  logic [PA*DW-1:0] a_do;
  logic [PA*DW-1:0] a_di = '0;
  logic [PA-1:0]    a_en, a_we;
  logic [PA-1:0]    a_rdy = '0;

  logic [PB*AW-1:0] b_addr;
  logic [PB*DW-1:0] b_do;
  logic [PB*DW-1:0] b_di = '0;
  logic [PB-1:0]    b_en, b_we;
  logic [PB-1:0]    b_rdy = '0;

  wb_drp_multi #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PORTS(PA), .TIMEOUT(TO)) dut_a (
    .clk(clk), .rst_n(rst_n), .wb(bus_a.slave),
    .drp_addr(a_addr), .drp_do(a_do), .drp_di(a_di),
    .drp_en(a_en), .drp_we(a_we), .drp_rdy(a_rdy)
  );

  wb_drp_multi #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PORTS(PB), .TIMEOUT(TO)) dut_b (
    .clk(clk), .rst_n(rst_n), .wb(bus_b.slave),
    .drp_addr(b_addr), .drp_do(b_do), .drp_di(b_di),
    .drp_en(b_en), .drp_we(b_we), .drp_rdy(b_rdy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (bus_a.wb_ack_o || bus_a.wb_err_o) begin
      if (q_a.size() == 0) begin
        chk("a_unexpected_resp", {bus_a.wb_ack_o, bus_a.wb_err_o}, 2'b00);
      end else begin
        ea = q_a.pop_front();
        chk("a_resp_kind", {bus_a.wb_ack_o, bus_a.wb_err_o}, ea.err ? 2'b01 : 2'b10);
        chk("a_resp_dat", bus_a.wb_dat_o, ea.dat);
      end
    end
  end

  always @(negedge clk) begin
    if (bus_b.wb_ack_o || bus_b.wb_err_o) begin
      if (q_b.size() == 0) begin
        chk("b_unexpected_resp", {bus_b.wb_ack_o, bus_b.wb_err_o}, 2'b00);
      end else begin
        eb = q_b.pop_front();
        chk("b_resp_kind", {bus_b.wb_ack_o, bus_b.wb_err_o}, eb.err ? 2'b01 : 2'b10);
        chk("b_resp_dat", bus_b.wb_dat_o, eb.dat);
      end
    end
  end

  // One access on DUT A. Cycle n=0 is the cycle stb is first presented;
  // exp_kind: 0 ack, 1 err, 2 no response (cyc dropped).
  task automatic a_access(input string nm, input int unsigned sel, input logic [AW-1:0] adr,
                          input logic we, input logic [DW-1:0] wdat,
                          input int rdy_dly, input logic [DW-1:0] di,
                          input int decoy_port, input int decoy_cyc, input int drop_cyc,
                          input int exp_kind, input logic [DW-1:0] exp_dat, input int exp_lat);
    int en_cnt = 0;
    int resp_cyc = -1;
    logic [PA-1:0] onehot = '0;
    onehot[sel] = 1'b1;
    if (exp_kind != 2) q_a.push_back('{err: (exp_kind == 1), dat: exp_dat});
    bus_a.wb_adr_i = {SW'(sel), adr};
    bus_a.wb_dat_i = wdat;
    bus_a.wb_we_i  = we;
    bus_a.wb_stb_i = 1'b1;
    bus_a.wb_cyc_i = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      a_rdy = '0;
      a_di  = '0;
      if (resp_cyc >= 0 && n == resp_cyc + 1) break;
      if (n == drop_cyc) begin
        bus_a.wb_stb_i = 1'b0;
        bus_a.wb_cyc_i = 1'b0;
      end
      if (rdy_dly >= 0 && n == 1 + rdy_dly) begin
        a_rdy[sel] = 1'b1;
        a_di[sel*DW +: DW] = di;
      end
      if (n == decoy_cyc) a_rdy[decoy_port] = 1'b1;
      if (a_en != '0) begin
        en_cnt++;
        chk({nm, "_en_cycle"}, n, 1);
        chk({nm, "_en_port"}, a_en, onehot);
        chk({nm, "_we"}, a_we, we ? onehot : '0);
        chk({nm, "_drp_addr"}, a_addr[sel*AW +: AW], adr);
        chk({nm, "_drp_do"}, a_do[sel*DW +: DW], wdat);
      end
      if (resp_cyc < 0 && (bus_a.wb_ack_o || bus_a.wb_err_o)) resp_cyc = n;
      if (exp_kind == 2 && n == exp_lat + 2) break;
    end
    a_rdy = '0;
    bus_a.wb_stb_i = 1'b0;
    bus_a.wb_cyc_i = 1'b0;
    chk({nm, "_en_count"}, en_cnt, 1);
    if (exp_kind == 2) chk({nm, "_no_resp"}, resp_cyc < 0, 1'b1);
    else chk({nm, "_latency"}, resp_cyc, exp_lat);
    @(posedge clk); #1;
  endtask

  task automatic a_idle_rdy(input string nm, input int unsigned port);
    a_rdy[port] = 1'b1;
    @(posedge clk); #1;
    a_rdy = '0;
    repeat (3) begin
      @(posedge clk); #1;
      chk({nm, "_no_en"}, a_en, '0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int en_cnt;
    int resp_cyc;
    bus_a.wb_adr_i = '0; bus_a.wb_dat_i = '0; bus_a.wb_we_i = 1'b0;
    bus_a.wb_stb_i = 1'b0; bus_a.wb_cyc_i = 1'b0;
    bus_b.wb_adr_i = '0; bus_b.wb_dat_i = '0; bus_b.wb_we_i = 1'b0;
    bus_b.wb_stb_i = 1'b0; bus_b.wb_cyc_i = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_en", a_en, '0);
    chk("rst_a_we", a_we, '0);
    chk("rst_a_addr", a_addr, '0);
    chk("rst_a_do", a_do, '0);
    chk("rst_a_flags", {bus_a.wb_ack_o, bus_a.wb_err_o}, 2'b00);
    chk("rst_a_dat", bus_a.wb_dat_o, '0);
    chk("rst_b_en", b_en, '0);
    chk("rst_b_flags", {bus_b.wb_ack_o, bus_b.wb_err_o}, 2'b00);
    rst_n = 1'b1;
    @(posedge clk); #1;

    a_access("t1_rd_p0", 0, 16'h0012, 1'b0, 16'h0000, 3, 16'hBEEF, 0, -1, -1, 0, 16'hBEEF, 5);
    a_access("t2_wr_p3", 3, 16'h0040, 1'b1, 16'h1234, 1, 16'h0000, 0, -1, -1, 0, 16'hBEEF, 3);
    chk("t2_p0_addr", a_addr[0*AW +: AW], 16'h0012);
    chk("t2_p1_addr", a_addr[1*AW +: AW], 16'h0000);
    chk("t2_p2_addr", a_addr[2*AW +: AW], 16'h0000);
    chk("t2_p012_do", a_do[3*DW-1:0], '0);
    chk("t2_p3_do", a_do[3*DW +: DW], 16'h1234);

    a_access("t3_timeout", 1, 16'h0007, 1'b0, 16'h0000, -1, 16'h0000, 0, -1, -1, 1, 16'hFFFF, 18);
    a_idle_rdy("t3_late_rdy", 1);
    a_access("t3_after", 1, 16'h0008, 1'b0, 16'h0000, 2, 16'h5A5A, 0, -1, -1, 0, 16'h5A5A, 4);

    a_access("t5_decoy", 2, 16'h0100, 1'b0, 16'h0000, 4, 16'hC0DE, 1, 2, -1, 0, 16'hC0DE, 6);
    a_access("t5_rdy_at_to", 2, 16'h0101, 1'b0, 16'h0000, 16, 16'h1111, 0, -1, -1, 0, 16'h1111, 18);
    a_access("t5_wr_timeout", 1, 16'h0002, 1'b1, 16'h7777, -1, 16'h0000, 0, -1, -1, 1, 16'hFFFF, 18);
    a_access("t5_cyc_drop", 0, 16'h0021, 1'b0, 16'h0000, 2, 16'h2222, 0, -1, 2, 2, 16'h0000, 4);

    // Reset while DUT A waits on port 1.
    bus_a.wb_adr_i = {2'd1, 16'h0033};
    bus_a.wb_we_i  = 1'b0;
    bus_a.wb_stb_i = 1'b1;
    bus_a.wb_cyc_i = 1'b1;
    @(posedge clk); #1;
    chk("t6_en_before", a_en, 4'b0010);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("t6_rst_en", a_en, '0);
    chk("t6_rst_we", a_we, '0);
    chk("t6_rst_addr", a_addr, '0);
    chk("t6_rst_do", a_do, '0);
    chk("t6_rst_dat", bus_a.wb_dat_o, '0);
    chk("t6_rst_flags", {bus_a.wb_ack_o, bus_a.wb_err_o}, 2'b00);
    rst_n = 1'b1;
    bus_a.wb_stb_i = 1'b0;
    bus_a.wb_cyc_i = 1'b0;
    @(posedge clk); #1;
    a_idle_rdy("t6_late_rdy", 1);
    a_access("t6_fresh", 0, 16'h0003, 1'b0, 16'h0000, 1, 16'h0F0F, 0, -1, -1, 0, 16'h0F0F, 3);

    // DUT B: select 3 is out of range for 3 ports.
    q_b.push_back('{err: 1'b1, dat: 16'h0000});
    bus_b.wb_adr_i = {2'd3, 16'h0055};
    bus_b.wb_we_i  = 1'b0;
    bus_b.wb_stb_i = 1'b1;
    bus_b.wb_cyc_i = 1'b1;
    en_cnt = 0;
    resp_cyc = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (resp_cyc >= 0 && n == resp_cyc + 1) break;
      if (b_en != '0) en_cnt++;
      if (resp_cyc < 0 && (bus_b.wb_ack_o || bus_b.wb_err_o)) resp_cyc = n;
    end
    bus_b.wb_stb_i = 1'b0;
    bus_b.wb_cyc_i = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (b_en != '0) en_cnt++;
    end
    chk("t4_bad_sel_latency", resp_cyc, 1);
    chk("t4_bad_sel_no_en", en_cnt, 0);

    q_b.push_back('{err: 1'b0, dat: 16'hAAAA});
    bus_b.wb_adr_i = {2'd2, 16'h0009};
    bus_b.wb_stb_i = 1'b1;
    bus_b.wb_cyc_i = 1'b1;
    resp_cyc = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      b_rdy = '0;
      b_di  = '0;
      if (resp_cyc >= 0 && n == resp_cyc + 1) break;
      if (n == 1) chk("t4_b_en_p2", b_en, 3'b100);
      if (n == 2) begin
        b_rdy[2] = 1'b1;
        b_di[2*DW +: DW] = 16'hAAAA;
      end
      if (resp_cyc < 0 && (bus_b.wb_ack_o || bus_b.wb_err_o)) resp_cyc = n;
    end
    bus_b.wb_stb_i = 1'b0;
    bus_b.wb_cyc_i = 1'b0;
    chk("t4_b_good_latency", resp_cyc, 3);

    repeat (3) @(posedge clk);
    #1;
    chk("a_queue_drained", q_a.size(), 0);
    chk("b_queue_drained", q_b.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
